// File: rtl/project_io_mux_if.sv
// Wishbone slave bus between the Caravel management core and the project IO mux.
// Signal names follow the wrapper's wbs_* naming so the hookup reads one-to-one.
interface project_io_mux_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/project_io_mux.sv
// Hosts NUM_PROJ user designs behind one IO bank; a Wishbone-programmed sequencer
// isolates the pads, cycles project resets and then routes exactly one project.
module project_io_mux #(
  parameter int unsigned NUM_PROJ = 4,
  parameter int unsigned IO_W     = 38,
  parameter int unsigned GUARD    = 4,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  project_io_mux_if.slave          wb,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_out_i,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_oeb_i,
  output logic [IO_W-1:0]          io_out_o,
  output logic [IO_W-1:0]          io_oeb_o,
  output logic [NUM_PROJ-1:0]      proj_rst_o,
  output logic                     busy_o
);

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_SWCNT  = 8'h08;

  typedef enum logic [1:0] {S_IDLE, S_ISOLATE, S_RELEASE, S_ACTIVE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_o_q, dat_o_d;
  logic        lat_we_q, lat_we_d;
  logic [7:0]  lat_off_q, lat_off_d;
  logic [5:0]  lat_dat_q, lat_dat_d;   // {dat[16], dat[8], dat[3:0]}
  logic [1:0]  lat_sel_q, lat_sel_d;
  logic [3:0]  ctrl_sel_q, ctrl_sel_d;
  logic        ctrl_en_q, ctrl_en_d;
  logic        err_q, err_d;
  logic [15:0] swcnt_q, swcnt_d;
  logic        cur_vld_q, cur_vld_d;
  logic [3:0]  cur_sel_q, cur_sel_d;
  logic        pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [3:0]  pend_sel_q, pend_sel_d;

  logic        hit, first;
  logic        ctrl_wr, stat_wr;
  logic [3:0]  new_sel, req_sel, new_tgt_sel;
  logic        new_en, new_in_range, new_vld, new_bad;
  logic        req_vld, has_req, guard_done, busy;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{wb.wbs_dat_i[31:17], wb.wbs_dat_i[15:9], wb.wbs_dat_i[7:4],
                         wb.wbs_sel_i[3:2]};

  assign hit   = wb.wbs_adr_i[31:8] == BASE_ADR[31:8];
  // ack_q masks the second cycle of a held strobe so each access acks once
  assign first = wb.wbs_stb_i & wb.wbs_cyc_i & hit & ~ack_q;

  // Writes commit on the ack edge from the copy latched when the access was seen
  assign ctrl_wr = ack_q & lat_we_q & (lat_off_q == OFF_CTRL);
  assign stat_wr = ack_q & lat_we_q & (lat_off_q == OFF_STATUS);

  assign new_sel      = lat_sel_q[0] ? lat_dat_q[3:0] : ctrl_sel_q;
  assign new_en       = lat_sel_q[1] ? lat_dat_q[4]   : ctrl_en_q;
  assign new_in_range = {1'b0, new_sel} < 5'(NUM_PROJ);
  assign new_vld      = new_en & new_in_range;
  assign new_bad      = new_en & ~new_in_range;
  assign new_tgt_sel  = new_vld ? new_sel : 4'd0;

  // A fresh write overrides anything still pending (last write wins)
  assign has_req = ctrl_wr | pend_q;
  assign req_vld = ctrl_wr ? new_vld     : pend_vld_q;
  assign req_sel = ctrl_wr ? new_tgt_sel : pend_sel_q;

  assign busy       = (state_q == S_ISOLATE) | (state_q == S_RELEASE);
  assign guard_done = cnt_q == 8'(GUARD - 1);

  always_comb begin
    rdata = 32'd0;
    case (wb.wbs_adr_i[7:0])
      OFF_CTRL:   rdata = {23'd0, ctrl_en_q, 4'd0, ctrl_sel_q};
      OFF_STATUS: rdata = {15'd0, err_q, 5'd0, pend_q, busy, state_q == S_ACTIVE, 4'd0, cur_sel_q};
      OFF_SWCNT:  rdata = {16'd0, swcnt_q};
      default:    rdata = 32'd0;
    endcase
  end

  always_comb begin
    ack_d     = first;
    dat_o_d   = first ? rdata : 32'd0;
    lat_we_d  = lat_we_q;
    lat_off_d = lat_off_q;
    lat_dat_d = lat_dat_q;
    lat_sel_d = lat_sel_q;
    if (first) begin
      lat_we_d  = wb.wbs_we_i;
      lat_off_d = wb.wbs_adr_i[7:0];
      lat_dat_d = {wb.wbs_dat_i[16], wb.wbs_dat_i[8], wb.wbs_dat_i[3:0]};
      lat_sel_d = wb.wbs_sel_i[1:0];
    end

    ctrl_sel_d = ctrl_sel_q;
    ctrl_en_d  = ctrl_en_q;
    err_d      = err_q;
    if (ctrl_wr) begin
      ctrl_sel_d = new_sel;
      ctrl_en_d  = new_en;
      if (new_bad) err_d = 1'b1;
    end else if (stat_wr && lat_dat_q[5]) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    swcnt_d    = swcnt_q;
    cur_vld_d  = cur_vld_q;
    cur_sel_d  = cur_sel_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    pend_sel_d = pend_sel_q;

    case (state_q)
      S_IDLE, S_ACTIVE: begin
        // IDLE always carries target none, so one compare covers both states
        if (has_req) begin
          pend_d = 1'b0;
          if ((req_vld != cur_vld_q) || (req_vld && (req_sel != cur_sel_q))) begin
            state_d   = S_ISOLATE;
            cnt_d     = 8'd0;
            cur_vld_d = req_vld;
            cur_sel_d = req_sel;
          end
        end
      end
      S_ISOLATE, S_RELEASE: begin
        if (ctrl_wr) begin
          pend_d     = 1'b1;
          pend_vld_d = new_vld;
          pend_sel_d = new_tgt_sel;
        end
        cnt_d = cnt_q + 8'd1;
        if (guard_done) begin
          cnt_d = 8'd0;
          if (state_q == S_RELEASE) begin
            state_d = S_ACTIVE;
            swcnt_d = swcnt_q + 16'd1;
          end else begin
            state_d = cur_vld_q ? S_RELEASE : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      ack_q      <= 1'b0;
      dat_o_q    <= 32'd0;
      lat_we_q   <= 1'b0;
      lat_off_q  <= 8'd0;
      lat_dat_q  <= 6'd0;
      lat_sel_q  <= 2'd0;
      ctrl_sel_q <= 4'd0;
      ctrl_en_q  <= 1'b0;
      err_q      <= 1'b0;
      swcnt_q    <= 16'd0;
      cur_vld_q  <= 1'b0;
      cur_sel_q  <= 4'd0;
      pend_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_sel_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      dat_o_q    <= dat_o_d;
      lat_we_q   <= lat_we_d;
      lat_off_q  <= lat_off_d;
      lat_dat_q  <= lat_dat_d;
      lat_sel_q  <= lat_sel_d;
      ctrl_sel_q <= ctrl_sel_d;
      ctrl_en_q  <= ctrl_en_d;
      err_q      <= err_d;
      swcnt_q    <= swcnt_d;
      cur_vld_q  <= cur_vld_d;
      cur_sel_q  <= cur_sel_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      pend_sel_q <= pend_sel_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_o_q;
  assign busy_o       = busy;

  logic [NUM_PROJ-1:0][IO_W-1:0] out_arr, oeb_arr;
  assign out_arr = proj_io_out_i;
  assign oeb_arr = proj_io_oeb_i;

  // Pads only see a project once its reset has been released for a full guard
  always_comb begin
    io_out_o = '0;
    io_oeb_o = '1;
    for (int k = 0; k < int'(NUM_PROJ); k++) begin
      if ((state_q == S_ACTIVE) && (cur_sel_q == 4'(k))) begin
        io_out_o = out_arr[k];
        io_oeb_o = oeb_arr[k];
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_PROJ); g++) begin : g_rst
    assign proj_rst_o[g] = ~(((state_q == S_RELEASE) || (state_q == S_ACTIVE)) &&
                             (cur_sel_q == 4'(g)));
  end

endmodule

// File: tb/tb_project_io_mux.sv
// Directed bench for project_io_mux: Wishbone reads go through a scoreboard queue,
// sequencing is checked cycle by cycle against the documented timeline.
module tb_project_io_mux;
  localparam int NP  = 4;
  localparam int IOW = 38;
  localparam logic [31:0] CTRL   = 32'h3000_0000;
  localparam logic [31:0] STATUS = 32'h3000_0004;
  localparam logic [31:0] SWCNT  = 32'h3000_0008;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  project_io_mux_if wb();
  logic [NP*IOW-1:0] pio_out, pio_oeb;
  logic [IOW-1:0]    io_out, io_oeb;
  logic [NP-1:0]     prst;
  logic              busy;
  logic [IOW-1:0]    pout [NP];
  logic [IOW-1:0]    poeb [NP];

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] sb_q [$];

  project_io_mux #(.NUM_PROJ(NP), .IO_W(IOW), .GUARD(4), .BASE_ADR(32'h3000_0000)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb(wb),
    .proj_io_out_i(pio_out), .proj_io_oeb_i(pio_oeb),
    .io_out_o(io_out), .io_oeb_o(io_oeb), .proj_rst_o(prst), .busy_o(busy)
  );

  always_comb begin
    pio_out = '0;
    pio_oeb = '0;
    for (int k = 0; k < NP; k++) begin
      pio_out[k*IOW +: IOW] = pout[k];
      pio_oeb[k*IOW +: IOW] = poeb[k];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output bit got);
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;  wb.wbs_sel_i = sel;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (wb.wbs_ack_o) got = 1'b1;
    end
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bit got;
    wb_cycle(1'b1, adr, dat, sel, got);
    chk($sformatf("wr_ack_%h", adr), 64'(got), 64'd1);
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    bit got;
    sb_q.push_back(exp);
    wb_cycle(1'b0, adr, 32'd0, 4'hF, got);
    if (!got) begin
      chk({tag, "_ack"}, 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end else begin
      chk(tag, 64'(wb.wbs_dat_o), 64'(sb_q.pop_front()));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_rel2, seen_ack, prev_busy;
    int rises;

    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = 32'd0; wb.wbs_dat_i = 32'd0;
    for (int k = 0; k < NP; k++) begin
      pout[k] = IOW'({$urandom(), $urandom()}) ^ IOW'(k << 34);
      poeb[k] = IOW'({$urandom(), $urandom()}) ^ IOW'(k << 30);
    end

    // reset values
    tick(); tick();
    chk("rst_oeb", 64'(io_oeb), 64'({IOW{1'b1}}));
    chk("rst_out", 64'(io_out), 64'd0);
    chk("rst_prst", 64'(prst), 64'hF);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(wb.wbs_ack_o), 64'd0);
    rst_n = 1'b1;
    tick();
    wb_read(STATUS, 32'h0, "rst_status");
    wb_read(SWCNT, 32'h0, "rst_swcnt");

    // first selection from IDLE: ack cycle A, cycle A+i sampled i edges later
    wb_write(CTRL, 32'h102, 4'hF);
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i <= 8) begin
        chk($sformatf("p2_busy_%0d", i), 64'(busy), 64'd1);
        chk($sformatf("p2_prst_%0d", i), 64'(prst), (i >= 5) ? 64'hB : 64'hF);
        chk($sformatf("p2_oeb_%0d", i), 64'(io_oeb), 64'({IOW{1'b1}}));
      end else begin
        chk("p2_busy_end", 64'(busy), 64'd0);
        chk("p2_out", 64'(io_out), 64'(pout[2]));
        chk("p2_oeb", 64'(io_oeb), 64'(poeb[2]));
        chk("p2_prst", 64'(prst), 64'hB);
      end
    end
    wb_read(SWCNT, 32'd1, "p2_swcnt");
    wb_read(STATUS, 32'h102, "p2_status");
    wb_read(CTRL, 32'h102, "p2_ctrl");

    // switch from ACTIVE 2 to project 1
    wb_write(CTRL, 32'h101, 4'hF);
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i <= 8) chk($sformatf("p1_prst_%0d", i), 64'(prst), (i >= 5) ? 64'hD : 64'hF);
      else begin
        chk("p1_out", 64'(io_out), 64'(pout[1]));
        chk("p1_busy_end", 64'(busy), 64'd0);
      end
    end
    wb_read(SWCNT, 32'd2, "p1_swcnt");

    // same target again: no re-sequence
    wb_write(CTRL, 32'h101, 4'hF);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("same_busy_%0d", i), 64'(busy), 64'd0);
    end
    wb_read(SWCNT, 32'd2, "same_swcnt");
    wb_read(STATUS, 32'h101, "same_status");

    // writes while busy: finish on 2, then exactly one re-sequence to 0
    wb_write(CTRL, 32'h102, 4'hF);
    wb_write(CTRL, 32'h103, 4'hF);
    wb_write(CTRL, 32'h100, 4'hF);
    saw_rel2 = 1'b0;
    rises = 0;
    prev_busy = busy;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (prst == 4'hB) saw_rel2 = 1'b1;
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
    end
    chk("pend_saw_rel2", 64'(saw_rel2), 64'd1);
    chk("pend_reseq_count", 64'(rises), 64'd1);
    chk("pend_out", 64'(io_out), 64'(pout[0]));
    chk("pend_prst", 64'(prst), 64'hE);
    wb_read(SWCNT, 32'd4, "pend_swcnt");
    wb_read(STATUS, 32'h100, "pend_status");

    // out-of-range select: err set, pads end isolated in IDLE
    wb_write(CTRL, 32'h10F, 4'hF);
    for (int i = 0; i < 12; i++) tick();
    chk("err_busy", 64'(busy), 64'd0);
    chk("err_oeb", 64'(io_oeb), 64'({IOW{1'b1}}));
    chk("err_out", 64'(io_out), 64'd0);
    chk("err_prst", 64'(prst), 64'hF);
    wb_read(STATUS, 32'h0001_0000, "err_status");
    wb_read(CTRL, 32'h10F, "err_ctrl");
    wb_read(SWCNT, 32'd4, "err_swcnt");
    wb_write(STATUS, 32'h0001_0000, 4'hF);
    wb_read(STATUS, 32'h0, "err_cleared");

    // unmapped offset, address miss, held strobe
    wb_read(32'h3000_000C, 32'h0, "unmapped_rd");
    wb_write(32'h3000_000C, 32'hFFFF_FFFF, 4'hF);
    wb_read(CTRL, 32'h10F, "unmapped_wr_ignored");
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b0;
    wb.wbs_adr_i = 32'h3000_0104;
    seen_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wb.wbs_ack_o) seen_ack = 1'b1;
    end
    chk("miss_no_ack", 64'(seen_ack), 64'd0);
    wb.wbs_adr_i = SWCNT;
    sb_q.push_back(32'd4);
    tick();
    chk("held_ack_first", 64'(wb.wbs_ack_o), 64'd1);
    chk("held_dat", 64'(wb.wbs_dat_o), 64'(sb_q.pop_front()));
    tick();
    chk("held_ack_low", 64'(wb.wbs_ack_o), 64'd0);
    chk("held_dat_zero", 64'(wb.wbs_dat_o), 64'd0);
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0;
    tick();

    // byte-lane write keeps en=1 and selects 3; reset lands mid-RELEASE
    wb_write(CTRL, 32'h0000_0003, 4'b0001);
    for (int i = 1; i <= 6; i++) tick();
    chk("midrel_prst", 64'(prst), 64'h7);
    chk("midrel_busy", 64'(busy), 64'd1);
    wb_write(CTRL, 32'h100, 4'hF);
    rst_n = 1'b0;
    #1;
    chk("arst_prst", 64'(prst), 64'hF);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_oeb", 64'(io_oeb), 64'({IOW{1'b1}}));
    chk("arst_out", 64'(io_out), 64'd0);
    chk("arst_ack", 64'(wb.wbs_ack_o), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    seen_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy) seen_ack = 1'b1;
    end
    chk("post_rst_idle", 64'(seen_ack), 64'd0);
    wb_read(STATUS, 32'h0, "post_rst_status");
    wb_read(SWCNT, 32'h0, "post_rst_swcnt");
    wb_read(CTRL, 32'h0, "post_rst_ctrl");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
